// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with a one-deep registered output and valid/ready
// handshakes; fixed-key select or round-robin arbitration across requesters.
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          key,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_any;
  logic [SEL_W-1:0]    rr_ptr;
  logic                load_en;
  logic                xfer;

  logic [WIDTH-1:0]    data_p1;
  logic [SEL_W-1:0]    chan_p1;
  logic                vld_p1;

  // Successor of a channel index, wrapping at CHANNELS rather than 2**SEL_W.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    if (int'(idx) >= CHANNELS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Grant selection: at most one channel, chosen by key or by rotating priority.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (key == SEL_W'(i) && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
          grant_any = 1'b1;
        end
      end
    end else begin
      for (int off = 0; off < CHANNELS; off++) begin
        idx = (int'(rr_ptr) + off) % CHANNELS;
        if (!grant_any && in_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

  // The register may take a new word when empty or when its word leaves this cycle.
  assign load_en  = !vld_p1 || out_ready;
  assign xfer     = grant_any && load_en && !reset;
  assign in_ready = xfer ? grant : '0;

  // Stage p1: output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= '0;
      chan_p1 <= '0;
      vld_p1  <= 1'b0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      data_p1 <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      chan_p1 <= grant_idx;
      vld_p1  <= 1'b1;
      if (mode) rr_ptr <= next_ptr(grant_idx);
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule
